// File: rtl/rvx_seq_alu.sv
// Sequential ALU: single-cycle ops finish in one edge, MUL is a shift-add multiplier
// that consumes one multiplier bit per cycle. Valid/ready handshake on both sides.
module rvx_seq_alu #(
  parameter int XLEN       = 32,
  parameter int ENABLE_MUL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;
  localparam logic [3:0] OP_MIN = 4'b1011;
  localparam logic [3:0] OP_MAX = 4'b1100;
  localparam logic [3:0] OP_ABS = 4'b1101;
  localparam logic [3:0] OP_MUL = 4'b1110;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e          state, state_nxt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mcand, mplier, acc, acc_next;
  logic [SHW-1:0]  cnt, shamt;
  logic [SHW:0]    rshamt;
  logic            start_mul, last_iter, slt;

  // Only the low log2(XLEN) bits of b steer shifts; rshamt is the complementary
  // amount for rotates (equals XLEN when shamt is 0, which shifts everything out).
  assign shamt     = b[SHW-1:0];
  assign rshamt    = (SHW+1)'(XLEN) - {1'b0, shamt};
  assign start_mul = (ENABLE_MUL != 0) && (op == OP_MUL);
  assign last_iter = (cnt == CNT_LAST);
  assign acc_next  = mplier[0] ? acc + mcand : acc;
  assign slt       = $signed(a) < $signed(b);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_ROL:  alu_res = (a << shamt) | (a >> rshamt);
      OP_ROR:  alu_res = (a >> shamt) | (a << rshamt);
      OP_MIN:  alu_res = slt ? a : b;
      OP_MAX:  alu_res = slt ? b : a;
      OP_ABS:  alu_res = a[XLEN-1] ? -a : a;
      default: alu_res = '0;  // MUL is handled iteratively; 1111 is reserved
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = start_mul ? MUL : DONE;
      MUL:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero      = (result == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_mul) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              result <= alu_res;
            end
          end
        end
        MUL: begin
          // One multiplier bit per cycle, LSB first; result only moves on the final step.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) result <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rvx_seq_alu.sv
// Bench for rvx_seq_alu: a 32-bit instance with MUL and a 16-bit instance without,
// directed corner cases plus random ops checked against an arithmetic reference model.
module tb_rvx_seq_alu;

  logic        clk, reset, in_valid, out_ready, sel;
  logic [3:0]  op;
  logic [63:0] a, b;

  logic        iv32, in_ready32, out_valid32, zero32;
  logic [31:0] result32;
  logic        iv16, in_ready16, out_valid16, zero16;
  logic [15:0] result16;

  logic        in_ready_o, out_valid_o, zero_o;
  logic [63:0] result_o;

  int n_cmp = 0;
  int n_mis = 0;

  assign iv32 = in_valid && !sel;
  assign iv16 = in_valid && sel;

  rvx_seq_alu #(.XLEN(32), .ENABLE_MUL(1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(in_ready32), .op(op),
    .a(a[31:0]), .b(b[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .result(result32), .zero(zero32)
  );

  rvx_seq_alu #(.XLEN(16), .ENABLE_MUL(0)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(in_ready16), .op(op),
    .a(a[15:0]), .b(b[15:0]), .out_valid(out_valid16), .out_ready(out_ready),
    .result(result16), .zero(zero16)
  );

  assign in_ready_o  = sel ? in_ready16  : in_ready32;
  assign out_valid_o = sel ? out_valid16 : out_valid32;
  assign zero_o      = sel ? zero16      : zero32;
  assign result_o    = sel ? {48'd0, result16} : {32'd0, result32};

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the op table, using plain 64-bit arithmetic.
  function automatic logic [63:0] ref_alu(input int w, input bit mul_en, input logic [3:0] f,
                                          input logic [63:0] xi, input logic [63:0] yi);
    logic [63:0] mask, x, y;
    longint      sx, sy;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    x  = xi & mask;
    y  = yi & mask;
    sx = x[w-1] ? longint'(x | ~mask) : longint'(x);
    sy = y[w-1] ? longint'(y | ~mask) : longint'(y);
    sh = int'(y[15:0]) % w;
    case (f)
      4'd0:    return (x + y) & mask;
      4'd1:    return (x - y) & mask;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return (sx < sy) ? 64'd1 : 64'd0;
      4'd6:    return (x << sh) & mask;
      4'd7:    return x >> sh;
      4'd8:    return 64'(sx >>> sh) & mask;
      4'd9:    return (sh == 0) ? x : ((x << sh) | (x >> (w - sh))) & mask;
      4'd10:   return (sh == 0) ? x : ((x >> sh) | (x << (w - sh))) & mask;
      4'd11:   return (sx < sy) ? x : y;
      4'd12:   return (sx < sy) ? y : x;
      4'd13:   return (sx < 0) ? (64'(-sx) & mask) : x;
      4'd14:   return mul_en ? ((x * y) & mask) : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] pick(input int w);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return 64'd1 << (w - 1);
      3:       return 64'($urandom_range(0, 40));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One full transaction on the selected instance: accept, latency, result, hold, release.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [63:0] x,
                        input logic [63:0] y, input int stall, input bit use_exp,
                        input logic [63:0] exp_i, input bit poke);
    int          w, lat, exp_lat;
    bit          is_mul;
    logic [63:0] expv;
    w       = sel ? 16 : 32;
    is_mul  = !sel && (f == 4'he);
    expv    = use_exp ? exp_i : ref_alu(w, !sel, f, x, y);
    exp_lat = is_mul ? w + 1 : 1;
    check($sformatf("%s in_ready before accept", tag), 64'(in_ready_o), 64'd1);
    op = f; a = x; b = y; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      if (lat == 2) check($sformatf("%s in_ready while busy", tag), 64'(in_ready_o), 64'd0);
      if (poke) in_valid = (lat >= 5 && lat < 9);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s result", tag), result_o, expv);
    check($sformatf("%s zero", tag), 64'(zero_o), 64'(expv == 64'd0));
    check($sformatf("%s in_ready while done", tag), 64'(in_ready_o), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s hold out_valid", tag), 64'(out_valid_o), 64'd1);
      check($sformatf("%s hold result", tag), result_o, expv);
      check($sformatf("%s hold in_ready", tag), 64'(in_ready_o), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check($sformatf("%s back to idle in_ready", tag), 64'(in_ready_o), 64'd1);
    check($sformatf("%s back to idle out_valid", tag), 64'(out_valid_o), 64'd0);
    check($sformatf("%s result retained", tag), result_o, expv);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]  rf;
    logic [63:0] ra, rb;
    int          seen;

    clk = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    op = 4'd0; a = '0; b = '0;

    // Reset state is visible before any clock edge.
    #2;
    check("reset in_ready32", 64'(in_ready32), 64'd1);
    check("reset out_valid32", 64'(out_valid32), 64'd0);
    check("reset result32", 64'(result32), 64'd0);
    check("reset zero32", 64'(zero32), 64'd1);
    check("reset in_ready16", 64'(in_ready16), 64'd1);
    check("reset out_valid16", 64'(out_valid16), 64'd0);
    check("reset result16", 64'(result16), 64'd0);
    check("reset zero16", 64'(zero16), 64'd1);
    #21 reset = 1'b1;

    // First edge after reset release must accept.
    run_op("add wrap", 4'h0, 64'hFFFF_FFFF, 64'd1, 0, 1'b1, 64'd0, 1'b0);
    run_op("ror", 4'hA, 64'h8000_0001, 64'h21, 0, 1'b1, 64'hC000_0000, 1'b0);
    run_op("sra", 4'h8, 64'h8000_0000, 64'd4, 0, 1'b1, 64'hF800_0000, 1'b0);
    run_op("abs minneg", 4'hD, 64'h8000_0000, 64'd0, 0, 1'b1, 64'h8000_0000, 1'b0);
    run_op("mul", 4'hE, 64'h0001_0003, 64'h0000_0005, 0, 1'b1, 64'h0005_000F, 1'b1);
    run_op("slt stall", 4'h5, 64'hFFFF_FFFF, 64'd1, 5, 1'b1, 64'd1, 1'b0);
    run_op("reserved 1111", 4'hF, 64'h1234_5678, 64'h9ABC_DEF0, 1, 1'b1, 64'd0, 1'b0);

    // Reset in the middle of a multiply discards it.
    op = 4'he; a = 64'h0001_0003; b = 64'h0000_0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid-mul reset in_ready", 64'(in_ready32), 64'd1);
    check("mid-mul reset out_valid", 64'(out_valid32), 64'd0);
    check("mid-mul reset result", 64'(result32), 64'd0);
    @(negedge clk) reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32) seen++;
    end
    check("no out_valid after discarded mul", 64'(seen), 64'd0);
    run_op("add after reset", 4'h0, 64'd2, 64'd3, 0, 1'b1, 64'd5, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = pick(32);
      rb = pick(32);
      run_op($sformatf("rand32 #%0d op%0h", i, rf), rf, ra, rb, $urandom_range(0, 3), 1'b0, 64'd0, 1'b0);
    end

    // 16-bit instance without the multiplier.
    sel = 1'b1;
    run_op("mul disabled", 4'he, 64'd3, 64'd4, 0, 1'b1, 64'd0, 1'b0);
    run_op("rol16", 4'h9, 64'h8001, 64'h11, 0, 1'b1, 64'h0003, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = pick(16);
      rb = pick(16);
      run_op($sformatf("rand16 #%0d op%0h", i, rf), rf, ra, rb, $urandom_range(0, 2), 1'b0, 64'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
